vend_ctrl_nprod: RTL and testbench

//  Second-generation vending controller FSM for NUM_PROD products. Owns the credit register, the per-state

---
 rtl/vend_pkg.sv | 54 +++++
 rtl/vend_if.sv | 29 ++
 rtl/vend_timeout_cnt.sv | 23 ++
 rtl/vend_ctrl_nprod.sv | 173 +++++++++++++++++
 tb/tb_vend_ctrl_nprod.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: state codes,
// selection error codes, LED patterns and a constant log2 helper.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_WAIT_COIN = 3'b001,
        ST_SELECT    = 3'b010,
        ST_CHANGE    = 3'b011,
        ST_DISPENSE  = 3'b100,
        ST_REFUND    = 3'b101,
        ST_FAULT     = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_INSUF = 2'b01,
        ERR_SOLD  = 2'b10,
        ERR_IDX   = 2'b11
    } err_t;

    localparam logic [3:0] LED_IDLE     = 4'b0000;
    localparam logic [3:0] LED_WAIT     = 4'b0001;
    localparam logic [3:0] LED_SELECT   = 4'b0010;
    localparam logic [3:0] LED_DISPENSE = 4'b0011;
    localparam logic [3:0] LED_CHANGE   = 4'b0100;
    localparam logic [3:0] LED_REFUND   = 4'b0101;
    localparam logic [3:0] LED_FAULT    = 4'b1000;

    // Smallest r with 2**r >= v; used for index and timer widths.
    function automatic int vend_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [3:0] led_of(input state_t s);
        logic [3:0] l;
        case (s)
            ST_WAIT_COIN: l = LED_WAIT;
            ST_SELECT:    l = LED_SELECT;
            ST_CHANGE:    l = LED_CHANGE;
            ST_DISPENSE:  l = LED_DISPENSE;
            ST_REFUND:    l = LED_REFUND;
            ST_FAULT:     l = LED_FAULT;
            default:      l = LED_IDLE;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Coin/selection inputs and the dispenser/change req-ack handshakes.
// master = controller side, slave = front-end and datapath side.
interface vend_if #(
    parameter int NUM_PROD = 4,
    parameter int CREDIT_W = 8
);
    localparam int IDX_W = vend_pkg::vend_clog2(NUM_PROD);

    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic                disp_req;
    logic [IDX_W-1:0]    disp_idx;
    logic                disp_ack;
    logic                chg_req;
    logic [CREDIT_W-1:0] chg_amount;
    logic                chg_ack;

    modport master (
        input  coin_valid, coin_value, sel_valid, sel_idx, disp_ack, chg_ack,
        output disp_req, disp_idx, chg_req, chg_amount
    );

    modport slave (
        output coin_valid, coin_value, sel_valid, sel_idx, disp_ack, chg_ack,
        input  disp_req, disp_idx, chg_req, chg_amount
    );
endinterface

// File: rtl/vend_timeout_cnt.sv
// Per-state activity timer: counts up from zero after a clear, saturates
// instead of wrapping, flags when the count equals the supplied terminal.
module vend_timeout_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] count;

    // Clear wins over counting; hold at all-ones so a long idle never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           count <= '0;
        else if (clear)                       count <= '0;
        else if (enable && (count != '1))     count <= count + 1'b1;
    end

    assign tc = (count == term);
endmodule

// File: rtl/vend_ctrl_nprod.sv
// Vending controller: credit register, price/stock checks, dispense and
// change handshakes, timeouts. All outputs registered except state_out/led.
//
// state     | meaning
// IDLE      | one-cycle pass-through back to coin acceptance
// WAIT_COIN | no credit yet, waiting for first coin
// SELECT    | credit held, waiting for a valid selection
// DISPENSE  | disp_req held until disp_ack
// CHANGE    | paying out residual credit after a sale
// REFUND    | paying out credit after cancel/timeout
// FAULT     | a handshake timed out; credit kept until cancel
module vend_ctrl_nprod
    import vend_pkg::*;
#(
    parameter int NUM_PROD = 4,
    parameter int CREDIT_W = 8,
    parameter int T_SEL    = 3000,
    parameter int T_DISP   = 500,
    parameter int T_CHG    = 500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cancel,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    input  logic [NUM_PROD-1:0]          stock_ok,
    vend_if.master                       bus,
    output logic [CREDIT_W-1:0]          credit,
    output logic [2:0]                   state_out,
    output logic                         coin_reject,
    output logic [1:0]                   err_code,
    output logic [3:0]                   led
);
    localparam int IDX_W  = vend_clog2(NUM_PROD);
    localparam int T_MAX0 = (T_SEL > T_DISP) ? T_SEL : T_DISP;
    localparam int T_MAX  = (T_MAX0 > T_CHG) ? T_MAX0 : T_CHG;
    localparam int TMR_W  = vend_clog2(T_MAX + 1);

    state_t              state, state_nxt;
    err_t                err_nxt;
    logic [CREDIT_W-1:0] credit_nxt, base, sel_price;
    logic [CREDIT_W:0]   sum;
    logic [IDX_W-1:0]    idx_nxt;
    logic [TMR_W-1:0]    tmr_term;
    logic                sel_stock, idx_bad, coin_ok, buy, chg_done, rej_nxt;
    logic                tmr_clr, tmr_tc, entering_pay;

    assign coin_ok      = bus.coin_valid && ((state == ST_WAIT_COIN) || (state == ST_SELECT));
    assign idx_bad      = ({1'b0, bus.sel_idx} >= (IDX_W+1)'(NUM_PROD));
    assign tmr_clr      = (state_nxt != state) || coin_ok;
    assign entering_pay = ((state_nxt == ST_CHANGE) || (state_nxt == ST_REFUND)) && (state_nxt != state);

    // Look up price and stock of the selected product with constant indices only.
    always_comb begin
        sel_price = '0;
        sel_stock = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (bus.sel_idx == IDX_W'(i)) begin
                sel_price = price_tbl[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock_ok[i];
            end
        end
    end

    // Timeout terminal for the current state; untimed states never reach all-ones usefully.
    always_comb begin
        case (state)
            ST_SELECT:           tmr_term = TMR_W'(T_SEL - 1);
            ST_DISPENSE:         tmr_term = TMR_W'(T_DISP - 1);
            ST_CHANGE, ST_REFUND: tmr_term = TMR_W'(T_CHG - 1);
            default:             tmr_term = '1;
        endcase
    end

    vend_timeout_cnt #(.W(TMR_W)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clr),
        .enable (1'b1),
        .term   (tmr_term),
        .tc     (tmr_tc)
    );

    // Next state, selection errors and purchase decision; acks beat same-cycle timeouts.
    always_comb begin
        state_nxt = state;
        idx_nxt   = bus.disp_idx;
        err_nxt   = ERR_NONE;
        buy       = 1'b0;
        chg_done  = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_WAIT_COIN;
            ST_WAIT_COIN: begin
                if (cancel)             state_nxt = ST_IDLE;
                else if (credit != '0)  state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (cancel || tmr_tc) begin
                    state_nxt = ST_REFUND;
                end else if (bus.sel_valid) begin
                    if (idx_bad)                 err_nxt = ERR_IDX;
                    else if (!sel_stock)         err_nxt = ERR_SOLD;
                    else if (credit < sel_price) err_nxt = ERR_INSUF;
                    else begin
                        buy       = 1'b1;
                        idx_nxt   = bus.sel_idx;
                        state_nxt = ST_DISPENSE;
                    end
                end
            end
            ST_DISPENSE: begin
                if (bus.disp_ack)  state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
                else if (tmr_tc)   state_nxt = ST_FAULT;
            end
            ST_CHANGE, ST_REFUND: begin
                if (bus.chg_ack) begin
                    chg_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmr_tc) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (cancel) state_nxt = (credit != '0) ? ST_REFUND : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Credit update: deduct price on a sale, add any accepted coin with saturation.
    always_comb begin
        base       = buy ? (credit - sel_price) : credit;
        sum        = {1'b0, base} + {1'b0, bus.coin_value};
        credit_nxt = base;
        rej_nxt    = 1'b0;
        if (coin_ok) begin
            if (sum[CREDIT_W]) begin
                credit_nxt = '1;
                rej_nxt    = 1'b1;
            end else begin
                credit_nxt = sum[CREDIT_W-1:0];
            end
        end else if (bus.coin_valid) begin
            rej_nxt = 1'b1;
        end
        if (chg_done) credit_nxt = '0;
    end

    // State, credit and registered outputs; change amount frozen on entry to a payout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            credit         <= '0;
            coin_reject    <= 1'b0;
            err_code       <= 2'b00;
            bus.disp_req   <= 1'b0;
            bus.disp_idx   <= '0;
            bus.chg_req    <= 1'b0;
            bus.chg_amount <= '0;
        end else begin
            state          <= state_nxt;
            credit         <= credit_nxt;
            coin_reject    <= rej_nxt;
            err_code       <= err_nxt;
            bus.disp_req   <= (state_nxt == ST_DISPENSE);
            bus.disp_idx   <= idx_nxt;
            bus.chg_req    <= (state_nxt == ST_CHANGE) || (state_nxt == ST_REFUND);
            if (entering_pay) bus.chg_amount <= credit_nxt;
        end
    end

    assign state_out = state;
    assign led       = led_of(state);
endmodule

// File: tb/tb_vend_ctrl_nprod.sv
// Bench for vend_ctrl_nprod: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a reference model.
module tb_vend_ctrl_nprod;
    localparam int NP = 4;
    localparam int CW = 8;
    localparam int TS = 60;
    localparam int TD = 25;
    localparam int TC = 30;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cancel = 1'b0;
    logic [NP*CW-1:0] price_tbl;
    logic [NP-1:0]    stock_ok;
    logic [CW-1:0]    credit;
    logic [2:0]       state_out;
    logic             coin_reject;
    logic [1:0]       err_code;
    logic [3:0]       led;

    vend_if #(.NUM_PROD(NP), .CREDIT_W(CW)) bus ();

    vend_ctrl_nprod #(.NUM_PROD(NP), .CREDIT_W(CW), .T_SEL(TS), .T_DISP(TD), .T_CHG(TC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cancel      (cancel),
        .price_tbl   (price_tbl),
        .stock_ok    (stock_ok),
        .bus         (bus),
        .credit      (credit),
        .state_out   (state_out),
        .coin_reject (coin_reject),
        .err_code    (err_code),
        .led         (led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state codes 0 idle,1 wait,2 select,3 change,4 dispense,5 refund,6 fault.
    int m_st, m_cred, m_age, m_idx, m_amt, m_err, m_rej;
    int coin_tbl[8] = '{1, 2, 5, 10, 25, 50, 100, 200};

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int led_for(int s);
        case (s)
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0100;
            4: return 4'b0011;
            5: return 4'b0101;
            6: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_cred = 0; m_age = 0; m_idx = 0; m_amt = 0; m_err = 0; m_rej = 0;
    endtask

    task automatic model_step();
        int nst, total, price, idx;
        bit accept, buy, done;
        if (!rst_n) return;
        nst = m_st; buy = 0; done = 0; m_err = 0; m_rej = 0;
        accept = bus.coin_valid && (m_st == 1 || m_st == 2);
        idx = int'(bus.sel_idx);
        price = (idx < NP) ? int'(price_tbl[idx*CW +: CW]) : 0;
        case (m_st)
            0: nst = 1;
            1: if (cancel) nst = 0; else if (m_cred != 0) nst = 2;
            2: begin
                if (cancel || m_age == TS - 1) nst = 5;
                else if (bus.sel_valid) begin
                    if (idx >= NP)          m_err = 3;
                    else if (!stock_ok[idx]) m_err = 2;
                    else if (m_cred < price) m_err = 1;
                    else begin buy = 1; nst = 4; m_idx = idx; end
                end
            end
            4: if (bus.disp_ack) nst = (m_cred != 0) ? 3 : 0; else if (m_age == TD - 1) nst = 6;
            3, 5: if (bus.chg_ack) begin nst = 0; done = 1; end else if (m_age == TC - 1) nst = 6;
            6: if (cancel) nst = (m_cred != 0) ? 5 : 0;
            default: nst = 0;
        endcase
        total = m_cred - (buy ? price : 0) + (accept ? int'(bus.coin_value) : 0);
        if (bus.coin_valid && !accept) m_rej = 1;
        if (total > (1 << CW) - 1) begin total = (1 << CW) - 1; m_rej = 1; end
        if (done) total = 0;
        m_age = (nst != m_st || accept) ? 0 : m_age + 1;
        if ((nst == 3 || nst == 5) && nst != m_st) m_amt = total;
        m_cred = total;
        m_st = nst;
    endtask

    task automatic compare_all();
        chk("state", int'(state_out), m_st);
        chk("led", int'(led), led_for(m_st));
        chk("credit", int'(credit), m_cred);
        chk("disp_req", int'(bus.disp_req), int'(m_st == 4));
        if (m_st == 4) chk("disp_idx", int'(bus.disp_idx), m_idx);
        chk("chg_req", int'(bus.chg_req), int'(m_st == 3 || m_st == 5));
        if (m_st == 3 || m_st == 5) chk("chg_amount", int'(bus.chg_amount), m_amt);
        chk("coin_reject", int'(coin_reject), m_rej);
        chk("err_code", int'(err_code), m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        bus.coin_valid = 1'b0;
        bus.sel_valid  = 1'b0;
        bus.disp_ack   = 1'b0;
        bus.chg_ack    = 1'b0;
    endtask

    task automatic coin(int v);
        bus.coin_valid = 1'b1;
        bus.coin_value = CW'(v);
        tick();
    endtask

    task automatic sel(int i);
        bus.sel_valid = 1'b1;
        bus.sel_idx   = 2'(i);
        tick();
    endtask

    task automatic run_until(int code, int budget, string name, output int n);
        n = 0;
        while (int'(state_out) != code && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(state_out), code);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.coin_valid = 1'b0; bus.coin_value = '0; bus.sel_valid = 1'b0; bus.sel_idx = '0;
        bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
        stock_ok  = '1;
        price_tbl = {8'd40, 8'd30, 8'd10, 8'd7};
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_state", int'(state_out), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_led", int'(led), 0);
        rst_n = 1'b1;

        // 5+5 buys product 1 exactly, no change
        tick();
        chk("t1_wait", int'(state_out), 1);
        chk("t1_wait_led", int'(led), 1);
        coin(5); coin(5);
        chk("t1_select", int'(state_out), 2);
        chk("t1_credit10", int'(credit), 10);
        sel(1);
        chk("t1_disp", int'(state_out), 4);
        chk("t1_disp_idx", int'(bus.disp_idx), 1);
        chk("t1_credit0", int'(credit), 0);
        chk("t1_disp_led", int'(led), 3);
        bus.disp_ack = 1'b1; tick();
        chk("t1_idle", int'(state_out), 0);
        chk("t1_no_chg", int'(bus.chg_req), 0);

        // 15 credit buys 10, change of 5
        tick(); coin(10); coin(5);
        chk("t2_credit15", int'(credit), 15);
        sel(1);
        chk("t2_credit5", int'(credit), 5);
        bus.disp_ack = 1'b1; tick();
        chk("t2_change", int'(state_out), 3);
        chk("t2_chg_amount", int'(bus.chg_amount), 5);
        chk("t2_chg_led", int'(led), 4);
        bus.chg_ack = 1'b1; tick();
        chk("t2_idle", int'(state_out), 0);
        chk("t2_credit0", int'(credit), 0);

        // insufficient credit, then sold out
        tick(); coin(5); tick();
        sel(1);
        chk("t3_err_insuf", int'(err_code), 1);
        chk("t3_stay", int'(state_out), 2);
        tick();
        chk("t3_err_clear", int'(err_code), 0);
        stock_ok = 4'b1101;
        sel(1);
        chk("t3_err_sold", int'(err_code), 2);
        stock_ok = '1;
        run_until(5, TS + 5, "t3_timeout_refund", n);
        chk("t3_refund_amt", int'(bus.chg_amount), 5);
        bus.chg_ack = 1'b1; tick();

        // selection timeout takes exactly T_SEL cycles in SELECT
        tick(); coin(7); tick();
        run_until(5, TS + 5, "t4_refund", n);
        chk("t4_tsel_cycles", n, TS);
        chk("t4_refund_amt", int'(bus.chg_amount), 7);
        bus.chg_ack = 1'b1; tick();

        // cancel in SELECT refunds
        tick(); coin(3); tick();
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t4_cancel_refund", int'(state_out), 5);
        chk("t4_cancel_amt", int'(bus.chg_amount), 3);
        bus.chg_ack = 1'b1; tick();

        // dispense timeout -> FAULT, cancel refunds residual
        tick(); coin(20); tick(); sel(1);
        run_until(6, TD + 5, "t5_fault", n);
        chk("t5_tdisp_cycles", n, TD);
        chk("t5_fault_led", int'(led), 8);
        chk("t5_no_disp_req", int'(bus.disp_req), 0);
        chk("t5_credit_kept", int'(credit), 10);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t5_refund", int'(state_out), 5);
        chk("t5_refund_amt", int'(bus.chg_amount), 10);
        bus.chg_ack = 1'b1; tick();

        // saturation, coin during dispense, reset mid-change
        tick(); coin(200); coin(100);
        chk("t6_sat", int'(credit), 255);
        chk("t6_sat_reject", int'(coin_reject), 1);
        sel(1);
        chk("t6_credit245", int'(credit), 245);
        coin(5);
        chk("t6_disp_reject", int'(coin_reject), 1);
        chk("t6_disp_credit", int'(credit), 245);
        bus.disp_ack = 1'b1; tick();
        chk("t6_chg_amt", int'(bus.chg_amount), 245);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_state", int'(state_out), 0);
        chk("t6_rst_credit", int'(credit), 0);
        chk("t6_rst_chg_req", int'(bus.chg_req), 0);
        chk("t6_rst_chg_amt", int'(bus.chg_amount), 0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                for (int i = 0; i < NP; i++) price_tbl[i*CW +: CW] = CW'($urandom_range(1, 60));
            end
            if ($urandom_range(0, 99) == 0) stock_ok = NP'($urandom);
            cancel = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 4) == 0) begin
                bus.coin_valid = 1'b1;
                bus.coin_value = CW'(coin_tbl[$urandom_range(0, 7)]);
            end
            if ($urandom_range(0, 5) == 0) begin
                bus.sel_valid = 1'b1;
                bus.sel_idx   = 2'($urandom_range(0, NP - 1));
            end
            bus.disp_ack = (m_st == 4) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
            bus.chg_ack  = (m_st == 3 || m_st == 5) ? ($urandom_range(0, 9) == 0)
                                                    : ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2999) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            tick();
            rst_n = 1'b1;
        end
        cancel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
